score_argmax: RTL and testbench

SCORE_ARGMAX -- requirements
Module: score_argmax

---
 rtl/score_argmax_if.sv | 35 +++
 rtl/score_argmax.sv | 151 +++++++++++++++
 tb/tb_score_argmax.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/score_argmax_if.sv
// score_argmax_if: frame handshake, class scores and classification result bus.
// With ARGMAX_TOP2_EN defined, the bus also carries the runner-up index and the margin to it.
interface score_argmax_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic                     en;
    logic                     ready_in;
    logic                     out_ack;
    logic signed [DATA_W-1:0] in0, in1, in2, in3, in4, in5, in6, in7, in8, in9;
    logic                     busy;
    logic                     out_valid;
    logic [3:0]               class_idx;
    logic signed [DATA_W-1:0] max_score;
    logic [CNT_W-1:0]         frame_cnt;
    logic                     overrun;
`ifdef ARGMAX_TOP2_EN
    logic [3:0]               second_idx;
    logic [DATA_W:0]          margin;
`endif
    modport master (
        output en, ready_in, out_ack, in0, in1, in2, in3, in4, in5, in6, in7, in8, in9,
        input  busy, out_valid, class_idx, max_score, frame_cnt, overrun
`ifdef ARGMAX_TOP2_EN
        , input second_idx, margin
`endif
    );
    modport slave (
        input  en, ready_in, out_ack, in0, in1, in2, in3, in4, in5, in6, in7, in8, in9,
        output busy, out_valid, class_idx, max_score, frame_cnt, overrun
`ifdef ARGMAX_TOP2_EN
        , output second_idx, margin
`endif
    );
endinterface

// File: rtl/score_argmax.sv
// score_argmax: sequential argmax over ten signed class scores, one compare per cycle.
// With ARGMAX_TOP2_EN defined, it also tracks the runner-up index and the margin to it.
module score_argmax #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input logic          clk,
    input logic          rst,
    score_argmax_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2;

    logic [1:0]               state_q, state_d;
    logic                     rdy_q;
    logic signed [DATA_W-1:0] in_a [10];
    logic signed [DATA_W-1:0] buf_q [10];
    logic signed [DATA_W-1:0] best_q, best_d, max_q, max_d, cand;
    logic [3:0]               idx_q, idx_d, cnt_q, cnt_d, class_q, class_d;
    logic [CNT_W-1:0]         frame_q, frame_d;
    logic                     valid_q, valid_d, ovr_q, ovr_d, start, take;
`ifdef ARGMAX_TOP2_EN
    logic signed [DATA_W-1:0] sec_q, sec_d;
    logic [3:0]               sidx_q, sidx_d, sec_out_q, sec_out_d;
    logic                     sv_q, sv_d;
    logic [DATA_W:0]          margin_q, margin_d;
`endif

    assign in_a  = '{bus.in0, bus.in1, bus.in2, bus.in3, bus.in4,
                     bus.in5, bus.in6, bus.in7, bus.in8, bus.in9};
    assign start = bus.ready_in & ~rdy_q;
    assign take  = start & bus.en & (state_q != SCAN);
    assign cand  = buf_q[cnt_q];

    always_ff @(posedge clk)
        if (take) buf_q <= in_a;

    always_comb begin
        state_d = state_q;
        best_d  = best_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        class_d = class_q;
        max_d   = max_q;
        frame_d = frame_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
`ifdef ARGMAX_TOP2_EN
        sec_d     = sec_q;
        sidx_d    = sidx_q;
        sv_d      = sv_q;
        sec_out_d = sec_out_q;
        margin_d  = margin_q;
`endif
        if (state_q == SCAN) begin
            // Strict compares keep the lower index on ties for both best and runner-up.
            if (cand > best_q) begin
`ifdef ARGMAX_TOP2_EN
                sec_d  = best_q;
                sidx_d = idx_q;
                sv_d   = 1'b1;
`endif
                best_d = cand;
                idx_d  = cnt_q;
            end
`ifdef ARGMAX_TOP2_EN
            else if (!sv_q || cand > sec_q) begin
                sec_d  = cand;
                sidx_d = cnt_q;
                sv_d   = 1'b1;
            end
`endif
            cnt_d = cnt_q + 4'd1;
            if (start && bus.en) ovr_d = 1'b1;
            if (cnt_q == 4'd9) begin
                state_d = DONE;
                valid_d = 1'b1;
                class_d = idx_d;
                max_d   = best_d;
                frame_d = frame_q + CNT_W'(1);
`ifdef ARGMAX_TOP2_EN
                sec_out_d = sidx_d;
                margin_d  = (DATA_W+1)'(best_d) - (DATA_W+1)'(sec_d);
`endif
            end
        end else if (take) begin
            state_d = SCAN;
            best_d  = in_a[0];
            idx_d   = 4'd0;
            cnt_d   = 4'd1;
            valid_d = 1'b0;
            ovr_d   = ovr_q | (state_q == DONE && !bus.out_ack);
`ifdef ARGMAX_TOP2_EN
            sv_d = 1'b0;
`endif
        end else if (state_q == DONE && bus.out_ack) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
            best_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            class_q <= '0;
            max_q   <= '0;
            frame_q <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef ARGMAX_TOP2_EN
            sec_q     <= '0;
            sidx_q    <= '0;
            sv_q      <= 1'b0;
            sec_out_q <= '0;
            margin_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            rdy_q   <= bus.ready_in;
            best_q  <= best_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            class_q <= class_d;
            max_q   <= max_d;
            frame_q <= frame_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
`ifdef ARGMAX_TOP2_EN
            sec_q     <= sec_d;
            sidx_q    <= sidx_d;
            sv_q      <= sv_d;
            sec_out_q <= sec_out_d;
            margin_q  <= margin_d;
`endif
        end
    end

    assign bus.busy      = (state_q == SCAN);
    assign bus.out_valid = valid_q;
    assign bus.class_idx = class_q;
    assign bus.max_score = max_q;
    assign bus.frame_cnt = frame_q;
    assign bus.overrun   = ovr_q;
`ifdef ARGMAX_TOP2_EN
    assign bus.second_idx = sec_out_q;
    assign bus.margin     = margin_q;
`endif
endmodule

// File: tb/tb_score_argmax.sv
// tb_score_argmax: directed checks of score_argmax; frame counter narrowed to 4 bits so wrap is reachable.
module tb_score_argmax;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    int   va [10] = '{0, 5, -3, 12, 7, 12, 1, 0, -8, 2};
    int   vb [10] = '{-100, -100, -100, -100, -100, -100, -100, -100, -100, -100};
    int   vc [10] = '{-5, -9, -2, -7, -3, -4, -6, -8, -10, -1};
    int   vx [10] = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};

    always #5 clk = ~clk;

    score_argmax_if #(.DATA_W(32), .CNT_W(4)) s ();
    score_argmax #(.DATA_W(32), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(s));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int v [10]);
        s.in0 = v[0]; s.in1 = v[1]; s.in2 = v[2]; s.in3 = v[3]; s.in4 = v[4];
        s.in5 = v[5]; s.in6 = v[6]; s.in7 = v[7]; s.in8 = v[8]; s.in9 = v[9];
    endtask

    task automatic start_frame(input int v [10]);
        set_in(v);
        s.ready_in = 1'b1;
        tick();
        s.ready_in = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_n);
        int n = 0;
        while (!s.out_valid && n < 20) begin
            chk({tag, " busy_scan"}, s.busy, 1);
            tick();
            n++;
        end
        chk({tag, " latency"}, n, exp_n);
        chk({tag, " busy_done"}, s.busy, 0);
    endtask

    task automatic check_res(input string tag, input int ci, input int mx, input int fc,
                             input int ov, input int si, input int mg);
        chk({tag, " out_valid"}, s.out_valid, 1);
        chk({tag, " class_idx"}, s.class_idx, ci);
        chk({tag, " max_score"}, s.max_score, mx);
        chk({tag, " frame_cnt"}, s.frame_cnt, fc);
        chk({tag, " overrun"}, s.overrun, ov);
`ifdef ARGMAX_TOP2_EN
        chk({tag, " second_idx"}, s.second_idx, si);
        chk({tag, " margin"}, s.margin, mg);
`else
        if (si < 0 || mg < 0) $display("note: unexpected top2 expectation in %s", tag);
`endif
    endtask

    task automatic ack();
        s.out_ack = 1'b1;
        tick();
        s.out_ack = 1'b0;
        chk("ack out_valid", s.out_valid, 0);
        chk("ack busy", s.busy, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " busy"}, s.busy, 0);
        chk({tag, " out_valid"}, s.out_valid, 0);
        chk({tag, " class_idx"}, s.class_idx, 0);
        chk({tag, " max_score"}, s.max_score, 0);
        chk({tag, " frame_cnt"}, s.frame_cnt, 0);
        chk({tag, " overrun"}, s.overrun, 0);
`ifdef ARGMAX_TOP2_EN
        chk({tag, " second_idx"}, s.second_idx, 0);
        chk({tag, " margin"}, s.margin, 0);
`endif
    endtask

    initial begin
        rst = 1'b1;
        s.en = 1'b0;
        s.ready_in = 1'b0;
        s.out_ack = 1'b0;
        set_in(va);
        #2;
        check_zero("reset");
        tick();
        tick();
        rst = 1'b0;
        s.en = 1'b1;

        // Basic frame; inputs change after the start edge and must be ignored.
        start_frame(va);
        set_in(vx);
        wait_done("A", 9);
        check_res("A", 3, 12, 1, 0, 5, 0);
        ack();

        start_frame(vb);
        wait_done("B", 9);
        check_res("B", 0, -100, 2, 0, 1, 0);
        ack();

        start_frame(vc);
        wait_done("C", 9);
        check_res("C", 9, -1, 3, 0, 2, 1);
        tick();

        // Start with en=0 is ignored and does not flag overrun.
        s.en = 1'b0;
        s.ready_in = 1'b1;
        tick();
        chk("en0 busy", s.busy, 0);
        chk("en0 out_valid", s.out_valid, 1);
        chk("en0 overrun", s.overrun, 0);
        s.ready_in = 1'b0;
        tick();
        s.en = 1'b1;

        // Start in DONE without ack drops the held result.
        start_frame(va);
        chk("drop busy", s.busy, 1);
        chk("drop out_valid", s.out_valid, 0);
        chk("drop overrun", s.overrun, 1);
        wait_done("drop", 9);
        check_res("drop", 3, 12, 4, 1, 5, 0);
        ack();

        // Reset at scan cycle 5 with ready_in held high.
        set_in(vb);
        s.ready_in = 1'b1;
        tick();
        repeat (4) tick();
        chk("pre_rst busy", s.busy, 1);
        rst = 1'b1;
        #1;
        check_zero("midscan_rst");
        rst = 1'b0;
        tick();
        wait_done("post_rst", 9);
        check_res("post_rst", 0, -100, 1, 0, 1, 0);
        s.ready_in = 1'b0;
        tick();

        // Start together with ack in DONE: no overrun.
        set_in(va);
        s.out_ack = 1'b1;
        s.ready_in = 1'b1;
        tick();
        s.out_ack = 1'b0;
        s.ready_in = 1'b0;
        chk("ackstart busy", s.busy, 1);
        chk("ackstart out_valid", s.out_valid, 0);
        chk("ackstart overrun", s.overrun, 0);
        wait_done("ackstart", 9);
        check_res("ackstart", 3, 12, 2, 0, 5, 0);
        ack();

        // Second start four cycles into SCAN is ignored but flagged.
        start_frame(vc);
        repeat (3) tick();
        set_in(va);
        s.ready_in = 1'b1;
        tick();
        s.ready_in = 1'b0;
        chk("scan_ovr busy", s.busy, 1);
        wait_done("scan_ovr", 5);
        check_res("scan_ovr", 9, -1, 3, 1, 2, 1);
        ack();

        // Frame counter wrap (4-bit counter).
        repeat (12) begin
            start_frame(vb);
            wait_done("fill", 9);
            ack();
        end
        chk("pre_wrap frame_cnt", s.frame_cnt, 15);
        start_frame(vb);
        wait_done("wrap", 9);
        chk("wrap frame_cnt", s.frame_cnt, 0);
        chk("wrap class_idx", s.class_idx, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
